// File: rtl/fifo_pkg.sv
// Shared constants, types and helpers for the FIFO buffer and its storage.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Sticky error flags kept together so they are set and cleared as a unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } errFlags_t;

  // Number of bits needed to address 'value' entries (ceil(log2(value))).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port word storage: one synchronous write port and one
// synchronous read port. A read and write to the same address in one cycle
// returns the previous contents, which is the native behaviour of iCE40
// block RAM. The array has no reset so it maps onto block RAM.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wrEn,
  input  logic [AW-1:0]    i_wrAddr,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic             i_rdEn,
  input  logic [AW-1:0]    i_rdAddr,
  output logic [WIDTH-1:0] o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdData;

  // Write and read on the same edge; the read sees the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/fifo_buffer_p.sv
// Synchronous FIFO with level tracking, almost-full threshold, sticky
// overflow/underflow flags and a choice of registered or first-word-fall-
// through read. Word storage lives in fifo_ram; this module owns pointers,
// occupancy, flags and the read-data presentation.
module fifo_buffer_p
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    I_DATA,
  input  logic                save,
  input  logic                pop,
  input  logic                clr_err,
  output logic [WIDTH-1:0]    O_DATA,
  output logic                O_VALID,
  output logic                full,
  output logic                empty,
  output logic                ALMOST_FULL,
  output logic [clog2(DEPTH):0] LEVEL,
  output logic                OVERFLOW,
  output logic                UNDERFLOW
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LEVEL = LW'(AFULL_TH);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [LW-1:0] LEVEL_ONE   = LW'(1);

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             r_oValid;
  logic             r_ramLoaded;
  logic             r_bypassValid;
  logic [WIDTH-1:0] r_bypassData;
  errFlags_t        r_errFlags;

  logic             w_full;
  logic             w_empty;
  logic             w_popAccept;
  logic             w_saveAccept;
  logic             w_setOverflow;
  logic             w_setUnderflow;
  logic             w_rdEn;
  logic [AW-1:0]    w_rdAddr;
  logic [WIDTH-1:0] w_ramRdData;

  // Occupancy flags come straight from the level register.
  always_comb begin
    w_full      = (r_level == FULL_LEVEL);
    w_empty     = (r_level == '0);
    ALMOST_FULL = (r_level >= AFULL_LEVEL);
  end

  // Handshake decisions: a pop frees a slot, so a write into a full FIFO is
  // still taken when it is paired with an accepted pop.
  always_comb begin
    w_popAccept    = pop & ~w_empty;
    w_saveAccept   = save & (~w_full | w_popAccept);
    w_setOverflow  = save & w_full & ~w_popAccept;
    w_setUnderflow = pop & w_empty;
  end

  // Read port control. Registered mode reads only on an accepted pop so the
  // RAM output register holds the last popped word. Fall-through mode reads
  // every cycle from the address that will be the head after this edge.
  always_comb begin
    w_rdEn   = w_popAccept;
    w_rdAddr = r_rdPtr;
    if (FWFT != 0) begin
      w_rdEn = 1'b1;
      if (w_popAccept) begin
        w_rdAddr = r_rdPtr + PTR_ONE;
      end
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk    (clk),
    .i_wrEn   (w_saveAccept),
    .i_wrAddr (r_wrPtr),
    .i_wrData (I_DATA),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_ramRdData)
  );

  // Read and write pointers advance on accepted transfers and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_saveAccept) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_popAccept) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  // Word count: up on write only, down on pop only, held when both happen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_saveAccept, w_popAccept})
        2'b10:   r_level <= r_level + LEVEL_ONE;
        2'b01:   r_level <= r_level - LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Read-side state. r_ramLoaded masks the un-resettable RAM output until
  // the first real read after reset. The bypass captures a word written to
  // the very address being read in fall-through mode, because the RAM
  // returns the old contents in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oValid      <= 1'b0;
      r_ramLoaded   <= 1'b0;
      r_bypassValid <= 1'b0;
      r_bypassData  <= '0;
    end else begin
      r_oValid      <= w_popAccept;
      r_ramLoaded   <= r_ramLoaded | w_popAccept;
      r_bypassValid <= (FWFT != 0) && w_saveAccept && (r_wrPtr == w_rdAddr);
      if (w_saveAccept) begin
        r_bypassData <= I_DATA;
      end
    end
  end

  // Sticky error flags; a fresh error in the clearing cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errFlags <= '0;
    end else begin
      r_errFlags.overflow  <= w_setOverflow  | (r_errFlags.overflow  & ~clr_err);
      r_errFlags.underflow <= w_setUnderflow | (r_errFlags.underflow & ~clr_err);
    end
  end

  // Output presentation for the selected read mode.
  always_comb begin
    O_DATA  = '0;
    O_VALID = 1'b0;
    if (FWFT != 0) begin
      O_VALID = ~w_empty;
      if (!w_empty) begin
        O_DATA = r_bypassValid ? r_bypassData : w_ramRdData;
      end
    end else begin
      O_VALID = r_oValid;
      if (r_ramLoaded) begin
        O_DATA = w_ramRdData;
      end
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign LEVEL     = r_level;
  assign OVERFLOW  = r_errFlags.overflow;
  assign UNDERFLOW = r_errFlags.underflow;

endmodule

// File: tb/tb_fifo_buffer_p.sv
// Directed bench for fifo_buffer_p: one registered-read instance and one
// first-word-fall-through instance sharing a clock.
module tb_fifo_buffer_p;

  logic       clk;
  logic       reset;
  logic [7:0] iData;
  logic       save;
  logic       pop;
  logic       clrErr;
  logic [7:0] oData;
  logic       oValid;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  logic       fReset;
  logic [7:0] fIData;
  logic       fSave;
  logic       fPop;
  logic       fClrErr;
  logic [7:0] fOData;
  logic       fOValid;
  logic       fFull;
  logic       fEmpty;
  logic       fAlmostFull;
  logic [4:0] fLevel;
  logic       fOverflow;
  logic       fUnderflow;

  int vectors;
  int miscompares;
  logic [7:0] model [$];

  fifo_buffer_p #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .I_DATA      (iData),
    .save        (save),
    .pop         (pop),
    .clr_err     (clrErr),
    .O_DATA      (oData),
    .O_VALID     (oValid),
    .full        (full),
    .empty       (empty),
    .ALMOST_FULL (almostFull),
    .LEVEL       (level),
    .OVERFLOW    (overflow),
    .UNDERFLOW   (underflow)
  );

  fifo_buffer_p #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk         (clk),
    .reset       (fReset),
    .I_DATA      (fIData),
    .save        (fSave),
    .pop         (fPop),
    .clr_err     (fClrErr),
    .O_DATA      (fOData),
    .O_VALID     (fOValid),
    .full        (fFull),
    .empty       (fEmpty),
    .ALMOST_FULL (fAlmostFull),
    .LEVEL       (fLevel),
    .OVERFLOW    (fOverflow),
    .UNDERFLOW   (fUnderflow)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the registered-read instance; returns 1 unit after the edge.
  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic [7:0] d);
    save = s; pop = p; clrErr = c; iData = d;
    @(posedge clk);
    #1;
    save = 1'b0; pop = 1'b0; clrErr = 1'b0;
  endtask

  // Drive one cycle on the fall-through instance.
  task automatic applyFwftStimulus(input logic s, input logic p, input logic [7:0] d);
    fSave = s; fPop = p; fIData = d;
    @(posedge clk);
    #1;
    fSave = 1'b0; fPop = 1'b0;
  endtask

  // Directed sequence covering reset, ordering, boundaries, errors and FWFT.
  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; fReset = 1'b1;
    save = 0; pop = 0; clrErr = 0; iData = '0;
    fSave = 0; fPop = 0; fClrErr = 0; fIData = '0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("rstLevel", level, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstAfull", almostFull, 0);
    checkOutput("rstValid", oValid, 0);
    checkOutput("rstData", oData, 8'h00);
    checkOutput("rstOvf", overflow, 0);
    checkOutput("rstUnf", underflow, 0);
    checkOutput("fRstValid", fOValid, 0);
    checkOutput("fRstEmpty", fEmpty, 1);
    reset = 1'b0; fReset = 1'b0;

    // Three words in, three out with one-cycle latency.
    applyStimulus(1, 0, 0, 8'hA5);
    applyStimulus(1, 0, 0, 8'h3C);
    applyStimulus(1, 0, 0, 8'hFF);
    checkOutput("basicLevel", level, 3);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("basicData0", oData, 8'hA5);
    checkOutput("basicValid0", oValid, 1);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("basicData1", oData, 8'h3C);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("basicData2", oData, 8'hFF);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("basicValidDrop", oValid, 0);
    checkOutput("basicHold", oData, 8'hFF);
    checkOutput("basicEmpty", empty, 1);

    // Pop while empty, clearing, and a new error during the clear.
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("unfFlag", underflow, 1);
    checkOutput("unfValid", oValid, 0);
    checkOutput("unfHold", oData, 8'hFF);
    checkOutput("unfLevel", level, 0);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("unfClear", underflow, 0);
    applyStimulus(0, 1, 1, 8'h00);
    checkOutput("unfClrPriority", underflow, 1);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("unfClear2", underflow, 0);

    // Save and pop together while empty: write only, underflow flagged.
    applyStimulus(1, 1, 0, 8'h77);
    checkOutput("emptyBothLevel", level, 1);
    checkOutput("emptyBothValid", oValid, 0);
    checkOutput("emptyBothUnf", underflow, 1);
    applyStimulus(0, 1, 1, 8'h00);
    checkOutput("emptyBothData", oData, 8'h77);
    checkOutput("emptyBothUnfClr", underflow, 0);

    // Fill to full, check thresholds, overflow, then read back in order.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1, 0, 0, 8'(k - 1));
      checkOutput("fillAfull", almostFull, (k >= 14) ? 1 : 0);
      checkOutput("fillFull", full, (k == 16) ? 1 : 0);
    end
    applyStimulus(1, 0, 0, 8'h99);
    checkOutput("ovfFlag", overflow, 1);
    checkOutput("ovfLevel", level, 16);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("fillReadback", oData, k);
      checkOutput("fillReadValid", oValid, 1);
    end
    checkOutput("fillDrainEmpty", empty, 1);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("ovfClear", overflow, 0);

    // Save and pop together while full.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 0, 0, 8'(8'h20 + k));
    end
    checkOutput("bndFull", full, 1);
    applyStimulus(1, 1, 0, 8'h55);
    checkOutput("bndOldHead", oData, 8'h20);
    checkOutput("bndLevel", level, 16);
    checkOutput("bndNoOvf", overflow, 0);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("bndDrain", oData, 8'h20 + k);
    end
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("bndLast", oData, 8'h55);
    checkOutput("bndEmpty", empty, 1);

    // Interleaved traffic at low occupancy, long enough to wrap pointers.
    model.delete();
    applyStimulus(1, 0, 0, 8'hC0); model.push_back(8'hC0);
    applyStimulus(1, 0, 0, 8'hC1); model.push_back(8'hC1);
    for (int i = 0; i < 40; i++) begin
      logic       doSave;
      logic       doPop;
      logic [7:0] d;
      logic [7:0] expWord;
      doSave  = (i % 3) != 1;
      doPop   = (i % 3) != 0;
      d       = 8'(i * 7 + 3);
      expWord = 8'h00;
      if (doPop) expWord = model.pop_front();
      if (doSave) model.push_back(d);
      applyStimulus(doSave, doPop, 0, d);
      if (doPop) checkOutput("wrapData", oData, expWord);
      checkOutput("wrapLevel", level, model.size());
    end
    while (model.size() > 0) begin
      logic [7:0] expWord;
      expWord = model.pop_front();
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("wrapDrain", oData, expWord);
    end
    applyStimulus(0, 0, 0, 8'h00);

    // Asynchronous reset in the middle of a save with five words stored.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 8'(8'h40 + k));
    end
    checkOutput("midLevel5", level, 5);
    save = 1'b1; iData = 8'h11;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midLevelNow", level, 0);
    checkOutput("midEmptyNow", empty, 1);
    checkOutput("midValidNow", oValid, 0);
    @(posedge clk);
    #1;
    checkOutput("midLevelHeld", level, 0);
    save = 1'b0;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("midNoValid", oValid, 0);
    checkOutput("midData", oData, 8'h00);
    checkOutput("midLevelAfter", level, 0);

    // First-word-fall-through instance.
    applyFwftStimulus(1, 0, 8'h81);
    checkOutput("fwftValid", fOValid, 1);
    checkOutput("fwftData", fOData, 8'h81);
    applyFwftStimulus(1, 0, 8'h82);
    checkOutput("fwftHeadHeld", fOData, 8'h81);
    checkOutput("fwftLevel", fLevel, 2);
    applyFwftStimulus(0, 1, 8'h00);
    checkOutput("fwftNext", fOData, 8'h82);
    checkOutput("fwftNextValid", fOValid, 1);
    applyFwftStimulus(0, 1, 8'h00);
    checkOutput("fwftDrained", fOValid, 0);
    checkOutput("fwftEmpty", fEmpty, 1);
    applyFwftStimulus(1, 0, 8'h90);
    applyFwftStimulus(1, 1, 8'h91);
    checkOutput("fwftSwapData", fOData, 8'h91);
    checkOutput("fwftSwapLevel", fLevel, 1);
    applyFwftStimulus(0, 1, 8'h00);
    checkOutput("fwftFinalEmpty", fEmpty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
